// File: rtl/ni_spike_arbiter_if.sv
// Link bundle for the spike arbiter: per-source FIFO read side plus the
// router injection valid/ready port and arbiter status.
interface ni_spike_arbiter_if #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_W      = $clog2(N_PORTS)
);
  logic                          enable;
  logic [N_PORTS-1:0]            fifo_empty;
  logic [N_PORTS*DATA_WIDTH-1:0] fifo_dout;
  logic [N_PORTS-1:0]            fifo_rd_en;
  logic [SRC_W+DATA_WIDTH-1:0]   out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [SRC_W-1:0]              grant_id;
  logic                          busy;

  modport master (
    input  enable, fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_data, out_valid, grant_id, busy
  );

  modport slave (
    output enable, fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_data, out_valid, grant_id, busy
  );
endinterface

// File: rtl/ni_spike_arbiter.sv
// Round-robin, burst-limited drain of N local spike FIFOs into one router
// injection port; FIFO read data arrives one cycle after the read enable.
module ni_spike_arbiter_chk #(
  parameter int N_PORTS = 4,
  parameter int PKT_W   = 34
) (
  input logic               clk,
  input logic               rst_n,
  input logic [N_PORTS-1:0] rd_en,
  input logic [N_PORTS-1:0] empty,
  input logic               out_valid,
  input logic               out_ready,
  input logic [PKT_W-1:0]   out_data
);
  a_rd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rd_en));

  a_no_empty_read: assert property (@(posedge clk) disable iff (!rst_n)
    ((rd_en & empty) == {N_PORTS{1'b0}}));

  a_hold_until_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
endmodule

module ni_spike_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST      = 4,
  parameter int SRC_W      = $clog2(N_PORTS)
) (
  input logic                clk,
  input logic                rst_n,
  ni_spike_arbiter_if.master bus
);
  localparam int              CNT_W     = $clog2(BURST + 1);
  localparam int              PKT_W     = SRC_W + DATA_WIDTH;
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_PORTS - 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [SRC_W-1:0]   grant_id_r;
  logic [SRC_W-1:0]   rr_ptr_r;
  logic [SRC_W-1:0]   sel_s;
  logic [CNT_W-1:0]   burst_cnt_r;
  logic [CNT_W-1:0]   burst_inc_s;
  logic [PKT_W-1:0]   out_data_r;
  logic               out_valid_r;
  logic [DATA_WIDTH-1:0] slice_s;
  logic [N_PORTS-1:0] rd_en_s;
  logic               any_req_s;
  logic               start_s;
  logic               grant_empty_s;
  logic               handshake_s;
  logic               burst_more_s;

  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int off);
    return SRC_W'((int'(base) + off) % N_PORTS);
  endfunction

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] g);
    return (g == LAST_SRC) ? {SRC_W{1'b0}} : g + SRC_W'(1'b1);
  endfunction

  assign any_req_s     = ~&bus.fifo_empty;
  assign start_s       = bus.enable && any_req_s;
  assign grant_empty_s = bus.fifo_empty[grant_id_r];
  assign slice_s       = bus.fifo_dout[int'(grant_id_r) * DATA_WIDTH +: DATA_WIDTH];
  assign handshake_s   = (state_r == SEND) && out_valid_r && bus.out_ready;
  assign burst_inc_s   = burst_cnt_r + CNT_W'(1'b1);
  // A burst continues only while the source still has data and the limit is not reached.
  assign burst_more_s  = (burst_inc_s < BURST_LIM) && bus.enable && !grant_empty_s;

  // Pick the first non-empty source at or after rr_ptr; lowest offset wins.
  always_comb begin
    sel_s = rr_ptr_r;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      sel_s = bus.fifo_empty[wrap_idx(rr_ptr_r, i)] ? sel_s : wrap_idx(rr_ptr_r, i);
    end
  end

  // Next-state decode of the grant sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = start_s ? READ : IDLE;
      READ:    next_state_s = grant_empty_s ? IDLE : LATCH;
      LATCH:   next_state_s = SEND;
      SEND: begin
        if (handshake_s) begin
          next_state_s = burst_more_s ? READ : IDLE;
        end else begin
          next_state_s = SEND;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Read strobe: one cycle in READ, suppressed if the source has gone empty.
  always_comb begin
    rd_en_s = {N_PORTS{1'b0}};
    if ((state_r == READ) && !grant_empty_s) begin
      rd_en_s[grant_id_r] = 1'b1;
    end else begin
      rd_en_s = {N_PORTS{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant, round-robin pointer, burst count and output packet registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id_r  <= {SRC_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
      out_data_r  <= {PKT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            grant_id_r  <= sel_s;
            burst_cnt_r <= {CNT_W{1'b0}};
          end
        end
        LATCH: begin
          out_data_r  <= {grant_id_r, slice_s};
          out_valid_r <= 1'b1;
        end
        SEND: begin
          if (handshake_s) begin
            out_valid_r <= 1'b0;
            burst_cnt_r <= burst_inc_s;
            if (!burst_more_s) begin
              rr_ptr_r <= next_ptr(grant_id_r);
            end
          end
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.out_data   = out_data_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.grant_id   = grant_id_r;
  assign bus.busy       = (state_r != IDLE);

  ni_spike_arbiter_chk #(
    .N_PORTS (N_PORTS),
    .PKT_W   (PKT_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en_s),
    .empty     (bus.fifo_empty),
    .out_valid (out_valid_r),
    .out_ready (bus.out_ready),
    .out_data  (out_data_r)
  );
endmodule

// File: tb/tb_ni_spike_arbiter.sv
// Directed bench for ni_spike_arbiter with a queue model of the source FIFOs.
module tb_ni_spike_arbiter;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int BURST = 4;
  localparam int SW    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ni_spike_arbiter_if #(.N_PORTS(N), .DATA_WIDTH(DW)) bus ();

  ni_spike_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0]    fq [N][$];
  logic [SW+DW-1:0] got_q [$];
  int               rd_cyc_q [$];
  logic [N-1:0]     rd_val_q [$];
  int cyc_n;
  int n_cmp;
  int n_err;
  int ovr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes and read strobes, then pop the FIFO model.
  task automatic cyc();
    logic [N-1:0] rd;
    @(posedge clk);
    rd = bus.fifo_rd_en;
    if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    if (rd != {N{1'b0}}) begin
      rd_cyc_q.push_back(cyc_n);
      rd_val_q.push_back(rd);
    end
    for (int i = 0; i < N; i++) begin
      if (rd[i]) begin
        if (fq[i].size() > 0) bus.fifo_dout[i*DW +: DW] <= fq[i].pop_front();
        else ovr++;
        bus.fifo_empty[i] <= (fq[i].size() == 0);
      end
    end
    cyc_n++;
    #1;
  endtask

  task automatic push(input int s, input logic [DW-1:0] w);
    fq[s].push_back(w);
    bus.fifo_empty[s] <= 1'b0;
  endtask

  task automatic clear_logs();
    got_q.delete();
    rd_cyc_q.delete();
    rd_val_q.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while ((bus.busy || bus.out_valid || bus.fifo_empty != {N{1'b1}}) && n < budget);
    chk(tag, 64'(n < budget), 64'(1));
  endtask

  function automatic logic [SW+DW-1:0] pkt(input int s, input logic [DW-1:0] w);
    return {SW'(s), w};
  endfunction

  function automatic logic [DW-1:0] wd(input int s, input int k);
    return {16'hC0DE, 8'(s), 8'(k)};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k0;
    int bad;
    int idx;
    n_cmp = 0; n_err = 0; ovr = 0; cyc_n = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo_empty <= {N{1'b1}};
    bus.fifo_dout  <= {N*DW{1'b0}};
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy",  64'(bus.busy),      64'(0));
    chk("rst_grant", 64'(bus.grant_id),  64'(0));
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    chk("rst_data",  64'(bus.out_data),  64'(0));
    cyc(); cyc();
    rst_n = 1'b1;
    bus.enable = 1'b1;
    bus.out_ready = 1'b1;

    // Single source, two words, three-cycle latency and pacing.
    clear_logs();
    k0 = cyc_n;
    push(2, 32'hAAAA_0001);
    push(2, 32'hBBBB_0002);
    cyc(); cyc();
    chk("t1_lat_pre", 64'(bus.out_valid), 64'(0));
    cyc();
    chk("t1_lat_valid", 64'(bus.out_valid), 64'(1));
    chk("t1_first", 64'(bus.out_data), 64'(pkt(2, 32'hAAAA_0001)));
    drain("t1_drain", 40);
    chk("t1_count", 64'(got_q.size()), 64'(2));
    chk("t1_pkt1", 64'(got_q[1]), 64'(pkt(2, 32'hBBBB_0002)));
    chk("t1_rd_n", 64'(rd_cyc_q.size()), 64'(2));
    chk("t1_rd0_cyc", 64'(rd_cyc_q[0]), 64'(k0 + 1));
    chk("t1_rd1_cyc", 64'(rd_cyc_q[1]), 64'(k0 + 4));
    chk("t1_rd0_val", 64'(rd_val_q[0]), 64'(4'b0100));
    chk("t1_rd1_val", 64'(rd_val_q[1]), 64'(4'b0100));
    chk("t1_idle", 64'(bus.busy), 64'(0));

    // Pointer now at 3: source 3 first, then wrap to source 0.
    clear_logs();
    push(3, 32'h3333_0003);
    push(0, 32'h0000_0F00);
    drain("t4_drain", 40);
    chk("t4_count", 64'(got_q.size()), 64'(2));
    chk("t4_pkt0", 64'(got_q[0]), 64'(pkt(3, 32'h3333_0003)));
    chk("t4_pkt1", 64'(got_q[1]), 64'(pkt(0, 32'h0000_0F00)));
    chk("t4_grant", 64'(bus.grant_id), 64'(0));

    // Backpressure: out_ready low for 10 cycles after valid rises.
    clear_logs();
    bus.out_ready = 1'b0;
    push(1, 32'h1234_5678);
    cyc(); cyc(); cyc();
    chk("t3_valid", 64'(bus.out_valid), 64'(1));
    chk("t3_data", 64'(bus.out_data), 64'(pkt(1, 32'h1234_5678)));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.out_valid !== 1'b1 || bus.out_data !== pkt(1, 32'h1234_5678)) bad++;
    end
    chk("t3_hold", 64'(bad), 64'(0));
    chk("t3_rd_once", 64'(rd_cyc_q.size()), 64'(1));
    chk("t3_no_hs", 64'(got_q.size()), 64'(0));
    bus.out_ready = 1'b1;
    cyc();
    chk("t3_hs_valid", 64'(bus.out_valid), 64'(0));
    chk("t3_got_n", 64'(got_q.size()), 64'(1));
    chk("t3_got", 64'(got_q[0]), 64'(pkt(1, 32'h1234_5678)));
    drain("t3_drain", 20);

    // enable dropped while the first word of a burst is in LATCH.
    clear_logs();
    push(2, wd(2, 0));
    push(2, wd(2, 1));
    push(2, wd(2, 2));
    cyc(); cyc();
    chk("t5_latch_busy", 64'(bus.busy), 64'(1));
    chk("t5_latch_valid", 64'(bus.out_valid), 64'(0));
    bus.enable = 1'b0;
    cyc();
    chk("t5_send_valid", 64'(bus.out_valid), 64'(1));
    cyc();
    chk("t5_hs_valid", 64'(bus.out_valid), 64'(0));
    cyc(); cyc();
    chk("t5_busy", 64'(bus.busy), 64'(0));
    for (int i = 0; i < 4; i++) cyc();
    chk("t5_busy_late", 64'(bus.busy), 64'(0));
    chk("t5_rd_n", 64'(rd_cyc_q.size()), 64'(1));
    chk("t5_got_n", 64'(got_q.size()), 64'(1));
    chk("t5_got", 64'(got_q[0]), 64'(pkt(2, wd(2, 0))));
    chk("t5_left", 64'(fq[2].size()), 64'(2));

    // Asynchronous reset while a word sits in SEND.
    bus.enable = 1'b1;
    bus.out_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("t6_send", 64'(bus.out_valid), 64'(1));
    chk("t6_grant", 64'(bus.grant_id), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("t6_rst_busy",  64'(bus.busy),      64'(0));
    chk("t6_rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    chk("t6_rst_grant", 64'(bus.grant_id),  64'(0));
    for (int i = 0; i < N; i++) fq[i].delete();
    bus.fifo_empty <= {N{1'b1}};
    cyc(); cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Full load after reset: bursts of 4 from 0..3, then 2 each from 0..3.
    clear_logs();
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 6; k++) push(s, wd(s, k));
    drain("t2_drain", 300);
    chk("t2_count", 64'(got_q.size()), 64'(24));
    idx = 0;
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t2_pkt%0d", idx), 64'(got_q[idx]), 64'(pkt(s, wd(s, k))));
        idx++;
      end
    for (int s = 0; s < N; s++)
      for (int k = 4; k < 6; k++) begin
        chk($sformatf("t2_pkt%0d", idx), 64'(got_q[idx]), 64'(pkt(s, wd(s, k))));
        idx++;
      end
    chk("t2_rd_n", 64'(rd_cyc_q.size()), 64'(24));

    chk("no_overread", 64'(ovr), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ni_spike_arbiter.md
Name: ni_spike_arbiter

Overview:
- Round-robin scheduler that drains N_PORTS local spike FIFOs (the network-interface FIFO instances) into the single router injection port of a neuromorphic NoC tile.
- Drives each FIFO's read enable and accounts for the FIFO's 1-cycle registered read latency.
- Tags each word with its source index and presents it on a valid/ready link to the router.
- Bounds per-source occupancy with a burst limit so that no cluster starves the others.

Parameters:
- N_PORTS, 4, number of requesting FIFOs (>=2).
- DATA_WIDTH, 32, FIFO word width.
- BURST, 4, maximum words taken from one source per grant (>=1).
- SRC_W, $clog2(N_PORTS), source-tag width (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new grant starts; the in-flight word completes.
- fifo_empty  input  N_PORTS  per-source FIFO empty flags.
- fifo_dout  input  N_PORTS*DATA_WIDTH  per-source FIFO read data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_rd_en  output  N_PORTS  per-source read enable, one-hot or zero.
- out_data  output  SRC_W+DATA_WIDTH  packet {src_id, word}.
- out_valid  output  1  packet valid.
- out_ready  input  1  router accepts the packet.
- grant_id  output  SRC_W  currently or last granted source.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, out_data=0, grant_id=0, rr_ptr=0, burst_cnt=0, busy=0, fifo_rd_en=0. Reset mid-transfer drops any captured word.
- FSM states: IDLE, READ, LATCH, SEND.
- IDLE: if enable and any fifo_empty bit is 0, select the first non-empty source searching from rr_ptr upward with wrap-around. Register it as grant_id, set burst_cnt=0, go to READ. Otherwise stay in IDLE.
- READ: fifo_rd_en[grant_id]=1 for exactly this cycle; all other bits are 0. fifo_rd_en is a combinational decode of the state and grant_id. If fifo_empty[grant_id]=1 in this cycle, fifo_rd_en stays 0 and the FSM returns to IDLE with rr_ptr unchanged. Otherwise go to LATCH.
- LATCH: fifo_dout slice is now valid. Register out_data={grant_id, slice}, set out_valid=1, go to SEND.
- SEND: out_valid and out_data are held stable until out_ready=1. Handshake completes on a clk edge where out_valid and out_ready are both 1. On that edge:
  - out_valid=0 and burst_cnt increments.
  - If burst_cnt+1 < BURST, enable=1, and fifo_empty[grant_id]=0, go to READ on the same source.
  - Otherwise set rr_ptr=(grant_id+1) mod N_PORTS and go to IDLE.
- Latency:
  - Non-empty source seen in IDLE at cycle 0 gives out_valid=1 at cycle 3.
  - A back-to-back word within a burst takes 3 cycles per word with out_ready held high.
- fifo_rd_en is never asserted outside READ, and never for an empty source. No read is issued while a captured word is unsent, so the FIFO can never be over-read.
- enable deasserted:
  - In READ/LATCH/SEND, the current word completes.
  - In SEND, the burst terminates after the handshake.
  - In IDLE, no grant is made.
- rr_ptr wrap-around: grant_id=N_PORTS-1 leads to rr_ptr=0.
- out_ready high outside SEND is ignored.

Test Plan:
- Only source 2 holds words A,B; out_ready=1; BURST=4: rd_en[2] pulses at cycles 1 and 4; packets {2,A}, {2,B}; then IDLE with rr_ptr=3.
- All 4 sources hold 6 words each; BURST=4; out_ready=1: output order is 4 words from src0, 4 from src1, 4 from src2, 4 from src3, then 2 from each source in order 0..3. Total 24 packets, none lost or duplicated.
- Source 1 holds word X; out_ready held low for 10 cycles after out_valid rises: out_data stays {1,X}, no further rd_en pulses, and the handshake completes on the first cycle out_ready=1.
- Sources 3 and 0 non-empty with rr_ptr=3: src3 is granted first, then src0 (wrap-around); grant_id sequence is 3 then 0.
- enable dropped during LATCH of the first word of a burst: that word is delivered, no further rd_en pulses, busy=0 two cycles after the handshake.
- rst_n asserted while in SEND: out_valid, busy, and fifo_rd_en go to 0 immediately (asynchronously). After release, arbitration restarts from rr_ptr=0.
